// File: rtl/scad_pkg.sv
// Shared constants for the DTN receive path: default widths and CU command encoding.
package scad_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 8;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    localparam logic CMD_FORWARD = 1'b0;
    localparam logic CMD_DISCARD = 1'b1;

endpackage

// File: rtl/buffer_input_if.sv
// Handshake bundles used around buffer_input: DTN messages, CU move commands, FU data.
interface message_interface import scad_pkg::*; #(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic [ADDR_WIDTH-1:0] from;
    logic [ADDR_WIDTH-1:0] to;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ack;

    modport producer (output from, output to, output data, output valid, input ack);
    modport consumer (input from, input to, input data, input valid, output ack);
endinterface

interface instruction_input_interface;
    logic move_discard;
    logic move_valid;
    logic move_ack;

    modport producer (output move_discard, output move_valid, input move_ack);
    modport consumer (input move_discard, input move_valid, output move_ack);
endinterface

interface data_interface import scad_pkg::*; #(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ack;

    modport producer (output data, output valid, input ack);
    modport consumer (input data, input valid, output ack);
endinterface

// File: rtl/fifo_sync_reset.sv
// Pointer FIFO with synchronous reset; no bypass, and no push while full even if popping.
module fifo_sync_reset #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             in,
    input  logic                         in_valid,
    output logic                         in_ack,
    output logic [WIDTH-1:0]             out,
    output logic                         out_valid,
    input  logic                         out_ack,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign in_ack    = in_valid && !w_full && !reset;
    assign out_valid = !w_empty && !reset;
    assign out       = r_mem[r_rd_ptr];
    assign count     = r_count;
    assign w_push    = in_ack;
    assign w_pop     = out_ack && out_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observable through the pointers.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= in;
    end

    a_count_bound: assert property (@(posedge clock) disable iff (reset) r_count <= CW'(DEPTH));
endmodule

// File: rtl/buffer_input.sv
// DTN receive buffer: queues messages for OWN_ADDR and forwards or discards each head on CU command.
module buffer_input import scad_pkg::*; #(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned OWN_ADDR   = 0,
    parameter int unsigned DEPTH      = 5
) (
    input  logic                          clock,
    input  logic                          reset,
    message_interface.consumer            dtn,
    instruction_input_interface.consumer  cu,
    data_interface.producer               data,
    output logic [ADDR_WIDTH-1:0]         from_head,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);
    localparam int unsigned MW = ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [MW-1:0] w_msg_in;
    logic [MW-1:0] w_msg_head;
    logic          w_msg_in_valid;
    logic          w_msg_valid;
    logic          w_cmd_valid;
    logic          w_cmd_head;
    logic          w_both_valid;
    logic          w_data_valid;
    logic          w_pop;
    logic [CW-1:0] w_unused_cmd_count;

    assign w_msg_in       = {dtn.from, dtn.data};
    assign w_msg_in_valid = dtn.valid && (dtn.to == ADDR_WIDTH'(OWN_ADDR));

    fifo_sync_reset #(
        .WIDTH (MW),
        .DEPTH (DEPTH)
    ) u_msg_fifo (
        .clock     (clock),
        .reset     (reset),
        .in        (w_msg_in),
        .in_valid  (w_msg_in_valid),
        .in_ack    (dtn.ack),
        .out       (w_msg_head),
        .out_valid (w_msg_valid),
        .out_ack   (w_pop),
        .count     (occupancy)
    );

    fifo_sync_reset #(
        .WIDTH (1),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clock     (clock),
        .reset     (reset),
        .in        (cu.move_discard),
        .in_valid  (cu.move_valid),
        .in_ack    (cu.move_ack),
        .out       (w_cmd_head),
        .out_valid (w_cmd_valid),
        .out_ack   (w_pop),
        .count     (w_unused_cmd_count)
    );

    // A message and its command always leave together, so both FIFOs stay paired.
    assign w_both_valid = w_msg_valid && w_cmd_valid;
    assign w_data_valid = w_both_valid && (w_cmd_head == CMD_FORWARD);
    assign w_pop        = w_both_valid && ((w_cmd_head == CMD_DISCARD) || data.ack);

    assign data.valid = w_data_valid;
    assign data.data  = w_msg_head[DATA_WIDTH-1:0];
    assign from_head  = w_msg_head[MW-1:DATA_WIDTH];

    a_valid_heads: assert property (@(posedge clock) disable iff (reset)
        w_data_valid |-> (w_msg_valid && w_cmd_valid));
    a_pop_heads: assert property (@(posedge clock) disable iff (reset)
        w_pop |-> w_both_valid);
    a_hold: assert property (@(posedge clock) disable iff (reset)
        (w_data_valid && !data.ack) |=> (w_data_valid && $stable(w_msg_head)));
endmodule

// File: tb/tb_buffer_input.sv
// Directed bench for buffer_input (OWN_ADDR=0, DEPTH=5) with immediate-assertion checks.
module tb_buffer_input;
    logic       clock;
    logic       reset;
    logic [3:0] occupancy;
    logic [7:0] from_head;
    int         n_pass;
    int         n_total;
    int         bad;

    message_interface #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dtn_if ();
    instruction_input_interface cu_if ();
    data_interface #(.DATA_WIDTH(32)) data_if ();

    buffer_input #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .OWN_ADDR   (0),
        .DEPTH      (5)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .dtn       (dtn_if),
        .cu        (cu_if),
        .data      (data_if),
        .from_head (from_head),
        .occupancy (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic send(input logic [7:0] to, input logic [7:0] from, input logic [31:0] d);
        dtn_if.valid = 1'b1;
        dtn_if.to    = to;
        dtn_if.from  = from;
        dtn_if.data  = d;
    endtask

    task automatic cmd(input logic discard);
        cu_if.move_valid   = 1'b1;
        cu_if.move_discard = discard;
    endtask

    task automatic idle();
        dtn_if.valid     = 1'b0;
        dtn_if.to        = '0;
        dtn_if.from      = '0;
        dtn_if.data      = '0;
        cu_if.move_valid = 1'b0;
        cu_if.move_discard = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        idle();
        data_if.ack = 1'b0;
        reset = 1'b1;
        tick();
        tick();

        // Reset holds all handshakes low even with requests present
        send(8'd0, 8'd1, 32'h1);
        cmd(1'b0);
        settle();
        check("rst_dtn_ack", dtn_if.ack, 0);
        check("rst_move_ack", cu_if.move_ack, 0);
        check("rst_data_valid", data_if.valid, 0);
        idle();
        reset = 1'b0;
        tick();
        check("rst_occupancy", occupancy, 0);

        // 1: single forward
        send(8'd0, 8'd3, 32'hDEADBEEF);
        settle();
        check("t1_dtn_ack", dtn_if.ack, 1);
        tick();
        idle();
        cmd(1'b0);
        settle();
        check("t1_move_ack", cu_if.move_ack, 1);
        check("t1_no_valid_without_cmd", data_if.valid, 0);
        check("t1_occ1", occupancy, 1);
        tick();
        idle();
        settle();
        check("t1_valid", data_if.valid, 1);
        check("t1_data", data_if.data, 32'hDEADBEEF);
        check("t1_from", from_head, 3);
        data_if.ack = 1'b1;
        tick();
        data_if.ack = 1'b0;
        settle();
        check("t1_occ0", occupancy, 0);
        check("t1_valid_off", data_if.valid, 0);

        // 2: forward A, discard B, forward C with ack held
        data_if.ack = 1'b1;
        send(8'd0, 8'd1, 32'hAAAA_AAAA);
        cmd(1'b0);
        tick();
        send(8'd0, 8'd2, 32'hBBBB_BBBB);
        cmd(1'b1);
        settle();
        check("t2_a_valid", data_if.valid, 1);
        check("t2_a_data", data_if.data, 32'hAAAA_AAAA);
        tick();
        send(8'd0, 8'd3, 32'hCCCC_CCCC);
        cmd(1'b0);
        settle();
        check("t2_b_no_valid", data_if.valid, 0);
        check("t2_b_occ", occupancy, 1);
        check("t2_b_from", from_head, 2);
        tick();
        idle();
        settle();
        check("t2_c_valid", data_if.valid, 1);
        check("t2_c_data", data_if.data, 32'hCCCC_CCCC);
        tick();
        data_if.ack = 1'b0;
        settle();
        check("t2_occ0", occupancy, 0);
        check("t2_valid_off", data_if.valid, 0);

        // 3: fill to DEPTH, sixth message blocked until a slot frees
        for (int i = 0; i < 5; i++) begin
            send(8'd0, 8'(i), 32'd100 + 32'(i));
            tick();
        end
        send(8'd0, 8'd6, 32'h66);
        settle();
        check("t3_occ_full", occupancy, 5);
        check("t3_full_no_ack", dtn_if.ack, 0);
        cmd(1'b0);
        tick();
        cu_if.move_valid = 1'b0;
        data_if.ack = 1'b1;
        settle();
        check("t3_head_data", data_if.data, 32'd100);
        check("t3_full_pop_no_ack", dtn_if.ack, 0);
        tick();
        data_if.ack = 1'b0;
        settle();
        check("t3_occ4", occupancy, 4);
        check("t3_sixth_ack", dtn_if.ack, 1);
        tick();
        idle();
        settle();
        check("t3_occ_refull", occupancy, 5);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            cmd(1'b1);
            settle();
            if (data_if.valid !== 1'b0) bad++;
            tick();
        end
        idle();
        settle();
        if (data_if.valid !== 1'b0) bad++;
        tick();
        check("t3_discard_no_valid", bad, 0);
        check("t3_drained", occupancy, 0);

        // 4: foreign destination is never accepted
        bad = 0;
        send(8'd7, 8'd1, 32'h7777);
        for (int i = 0; i < 20; i++) begin
            settle();
            if (dtn_if.ack !== 1'b0) bad++;
            tick();
        end
        idle();
        settle();
        check("t4_no_ack", bad, 0);
        check("t4_occ0", occupancy, 0);

        // 5: stall with ack low for 4 cycles
        send(8'd0, 8'd9, 32'h5555_5555);
        cmd(1'b0);
        tick();
        idle();
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            if (data_if.valid !== 1'b1 || data_if.data !== 32'h5555_5555 || occupancy !== 4'd1)
                bad++;
            tick();
        end
        check("t5_stable", bad, 0);
        data_if.ack = 1'b1;
        tick();
        data_if.ack = 1'b0;
        settle();
        check("t5_popped", occupancy, 0);

        // 6: reset mid-stream, then normal delivery
        send(8'd0, 8'd1, 32'h6001);
        cmd(1'b0);
        tick();
        send(8'd0, 8'd2, 32'h6002);
        cmd(1'b0);
        tick();
        send(8'd0, 8'd3, 32'h6003);
        cu_if.move_valid = 1'b0;
        tick();
        idle();
        settle();
        check("t6_occ3", occupancy, 3);
        check("t6_valid_before", data_if.valid, 1);
        reset = 1'b1;
        send(8'd0, 8'd5, 32'h6005);
        cmd(1'b0);
        settle();
        check("t6_rst_valid", data_if.valid, 0);
        check("t6_rst_dtn_ack", dtn_if.ack, 0);
        tick();
        reset = 1'b0;
        idle();
        settle();
        check("t6_occ_after", occupancy, 0);
        check("t6_valid_after", data_if.valid, 0);
        send(8'd0, 8'd4, 32'h0E0E_0E0E);
        cmd(1'b0);
        tick();
        idle();
        settle();
        check("t6_new_valid", data_if.valid, 1);
        check("t6_new_data", data_if.data, 32'h0E0E_0E0E);
        check("t6_new_from", from_head, 4);
        data_if.ack = 1'b1;
        tick();
        data_if.ack = 1'b0;
        settle();
        check("t6_occ_end", occupancy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
